// File: rtl/uart_tx_scheduler_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_tx_scheduler_pkg : FSM states, header tag and header-byte helper      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package uart_tx_scheduler_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  localparam logic [3:0] HDR_TAG = 4'hA;
  localparam int         ID_W    = 2;

  function automatic logic [7:0] hdr_byte(input logic [ID_W-1:0] id);
    return {HDR_TAG, 2'b00, id};
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_tx_scheduler_rr_arbiter : combinational round-robin pick from ptr     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module uart_tx_scheduler_rr_arbiter
  import uart_tx_scheduler_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    id
);

  logic found;

  // Offset k from ptr maps to requester n either directly or after one wrap.
  always_comb begin
    grant = '0;
    id    = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int n = 0; n < NUM_REQ; n++) begin
        if (en && !found && req[n] &&
            ((int'(ptr) + k == n) || (int'(ptr) + k == n + NUM_REQ))) begin
          grant[n] = 1'b1;
          id       = ID_W'(n);
          found    = 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_tx_scheduler : round-robin sharing of one uart_tx among requesters    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module uart_tx_scheduler
  import uart_tx_scheduler_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int WORD_BYTES   = 4,
  parameter int HDR_EN       = 1,
  parameter int TIMEOUT_CLKS = 200000
) (
  input  logic                          i_Clock,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            i_Req_Valid,
  input  logic [NUM_REQ*WORD_BYTES*8-1:0] i_Req_Data,
  output logic [NUM_REQ-1:0]            o_Req_Ready,
  output logic                          o_Tx_DV,
  output logic [7:0]                    o_Tx_Byte,
  input  logic                          i_Tx_Active,
  input  logic                          i_Tx_Done,
  output logic                          o_Busy,
  output logic [1:0]                    o_Grant_Id,
  output logic                          o_Timeout
);

  localparam int c_word_w      = WORD_BYTES * 8;
  localparam int c_idx_w       = $clog2(WORD_BYTES + 2);
  localparam int c_wdog_w      = $clog2(TIMEOUT_CLKS + 1);
  localparam int c_total_bytes = WORD_BYTES + HDR_EN;

  localparam logic [c_idx_w-1:0]  c_last_idx  = c_idx_w'(c_total_bytes - 1);
  localparam logic [c_wdog_w-1:0] c_wdog_last = c_wdog_w'(TIMEOUT_CLKS - 1);
  localparam logic [ID_W-1:0]     c_last_id   = ID_W'(NUM_REQ - 1);

  state_t                state_q, state_d;
  logic [ID_W-1:0]       ptr_q, ptr_d;
  logic [ID_W-1:0]       gid_q, gid_d;
  logic [c_idx_w-1:0]    idx_q, idx_d;
  logic [c_wdog_w-1:0]   wdog_q, wdog_d;
  logic [c_word_w-1:0]   word_q, word_d;
  logic [NUM_REQ-1:0]    ready_q, ready_d;
  logic [7:0]            byte_q, byte_d;
  logic                  busy_q, busy_d;
  logic                  dv_q, dv_d;
  logic                  timeout_q, timeout_d;
  logic                  done_q, done_d;

  logic [NUM_REQ-1:0]    arb_grant;
  logic [ID_W-1:0]       arb_id;
  logic [c_word_w-1:0]   sel_word;
  logic [7:0]            payload_byte;
  logic [7:0]            tx_byte_mux;
  logic [ID_W-1:0]       ptr_next;
  logic                  done_edge;
  logic                  arb_en;

  assign arb_en    = (state_q == S_IDLE) && !i_Tx_Active;
  assign done_d    = i_Tx_Done;
  // uart_tx holds Done for two clocks, so only its rising edge marks a byte.
  assign done_edge = i_Tx_Done & ~done_q;
  assign ptr_next  = (gid_q == c_last_id) ? '0 : gid_q + 1'b1;

  uart_tx_scheduler_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req   (i_Req_Valid),
    .ptr   (ptr_q),
    .en    (arb_en),
    .grant (arb_grant),
    .id    (arb_id)
  );

  always_comb begin
    sel_word = '0;
    for (int n = 0; n < NUM_REQ; n++) begin
      if (arb_grant[n]) sel_word = i_Req_Data[n*c_word_w +: c_word_w];
    end
  end

  // Byte index counts the header first when enabled, then payload MSB-first.
  always_comb begin
    payload_byte = '0;
    for (int b = 0; b < WORD_BYTES; b++) begin
      if (idx_q == c_idx_w'(b + HDR_EN)) payload_byte = word_q[(WORD_BYTES-1-b)*8 +: 8];
    end
    if ((HDR_EN != 0) && (idx_q == '0)) tx_byte_mux = hdr_byte(gid_q);
    else                                tx_byte_mux = payload_byte;
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gid_d     = gid_q;
    idx_d     = idx_q;
    wdog_d    = wdog_q;
    word_d    = word_q;
    busy_d    = busy_q;
    byte_d    = byte_q;
    ready_d   = '0;
    dv_d      = 1'b0;
    timeout_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (|arb_grant) begin
          ready_d = arb_grant;
          word_d  = sel_word;
          gid_d   = arb_id;
          busy_d  = 1'b1;
          idx_d   = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        dv_d    = 1'b1;
        byte_d  = tx_byte_mux;
        wdog_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (done_edge) begin
          if (idx_q == c_last_idx) begin
            busy_d  = 1'b0;
            ptr_d   = ptr_next;
            state_d = S_IDLE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_LOAD;
          end
        end else if (wdog_q == c_wdog_last) begin
          timeout_d = 1'b1;
          busy_d    = 1'b0;
          ptr_d     = ptr_next;
          state_d   = S_IDLE;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      gid_q     <= '0;
      idx_q     <= '0;
      wdog_q    <= '0;
      word_q    <= '0;
      busy_q    <= 1'b0;
      byte_q    <= '0;
      ready_q   <= '0;
      dv_q      <= 1'b0;
      timeout_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gid_q     <= gid_d;
      idx_q     <= idx_d;
      wdog_q    <= wdog_d;
      word_q    <= word_d;
      busy_q    <= busy_d;
      byte_q    <= byte_d;
      ready_q   <= ready_d;
      dv_q      <= dv_d;
      timeout_q <= timeout_d;
      done_q    <= done_d;
    end
  end

  assign o_Req_Ready = ready_q;
  assign o_Tx_DV     = dv_q;
  assign o_Tx_Byte   = byte_q;
  assign o_Busy      = busy_q;
  assign o_Grant_Id  = gid_q;
  assign o_Timeout   = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_uart_tx_scheduler : directed bench with a cycle model of uart_tx        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_uart_tx_scheduler;

  localparam int CPB     = 4;
  localparam int TX_CLKS = 10 * CPB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance A: 4 requesters, 4-byte words with header, short watchdog
  logic [3:0]   a_valid;
  logic [127:0] a_data;
  logic [3:0]   a_ready;
  logic         a_dv, a_busy, a_timeout, a_active, a_done, a_done_raw;
  logic [7:0]   a_byte;
  logic [1:0]   a_gid;
  logic         stub;

  // Instance B: 2 requesters, single payload byte, no header
  logic [1:0]   b_valid;
  logic [15:0]  b_data;
  logic [1:0]   b_ready;
  logic         b_dv, b_busy, b_timeout, b_active, b_done;
  logic [7:0]   b_byte;
  logic [1:0]   b_gid;

  uart_tx_scheduler #(
    .NUM_REQ(4), .WORD_BYTES(4), .HDR_EN(1), .TIMEOUT_CLKS(50)
  ) dut_a (
    .i_Clock(clk), .reset(rst), .i_Req_Valid(a_valid), .i_Req_Data(a_data),
    .o_Req_Ready(a_ready), .o_Tx_DV(a_dv), .o_Tx_Byte(a_byte),
    .i_Tx_Active(a_active), .i_Tx_Done(a_done), .o_Busy(a_busy),
    .o_Grant_Id(a_gid), .o_Timeout(a_timeout)
  );

  uart_tx_scheduler #(
    .NUM_REQ(2), .WORD_BYTES(1), .HDR_EN(0), .TIMEOUT_CLKS(50)
  ) dut_b (
    .i_Clock(clk), .reset(rst), .i_Req_Valid(b_valid), .i_Req_Data(b_data),
    .o_Req_Ready(b_ready), .o_Tx_DV(b_dv), .o_Tx_Byte(b_byte),
    .i_Tx_Active(b_active), .i_Tx_Done(b_done), .o_Busy(b_busy),
    .o_Grant_Id(b_gid), .o_Timeout(b_timeout)
  );

  // uart_tx models: Active for 10 bit times after DV, then Done high 2 clocks
  int a_cnt, a_dcnt, b_cnt, b_dcnt;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      a_active <= 1'b0; a_cnt <= 0; a_dcnt <= 0;
    end else begin
      if (a_dcnt != 0) a_dcnt <= a_dcnt - 1;
      if (!a_active && a_dv) begin
        a_active <= 1'b1; a_cnt <= TX_CLKS - 1;
      end else if (a_active) begin
        if (a_cnt == 0) begin a_active <= 1'b0; a_dcnt <= 2; end
        else a_cnt <= a_cnt - 1;
      end
    end
  end
  assign a_done_raw = (a_dcnt != 0);
  assign a_done     = a_done_raw & ~stub;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      b_active <= 1'b0; b_cnt <= 0; b_dcnt <= 0;
    end else begin
      if (b_dcnt != 0) b_dcnt <= b_dcnt - 1;
      if (!b_active && b_dv) begin
        b_active <= 1'b1; b_cnt <= TX_CLKS - 1;
      end else if (b_active) begin
        if (b_cnt == 0) begin b_active <= 1'b0; b_dcnt <= 2; end
        else b_cnt <= b_cnt - 1;
      end
    end
  end
  assign b_done = (b_dcnt != 0);

  // Event monitors sampled on the falling edge
  logic [7:0] a_log [0:255];
  int         a_grants [0:63];
  int a_nbytes = 0, a_nready = 0, a_rcycles = 0, a_ngrant = 0, a_nedges = 0;
  logic a_done_prev = 1'b0;
  logic [7:0] b_log [0:15];
  int b_nbytes = 0, b_nready = 0, b_nedges = 0;
  logic b_done_prev = 1'b0;

  always @(negedge clk) begin
    if (a_dv) begin a_log[a_nbytes[7:0]] = a_byte; a_nbytes++; end
    if (a_ready != 4'b0000) begin
      int g;
      g = 0;
      for (int n = 3; n >= 0; n--) if (a_ready[n]) g = n;
      a_grants[a_ngrant[5:0]] = g;
      a_ngrant++;
      a_rcycles++;
      a_nready += $countones(a_ready);
    end
    if (a_done && !a_done_prev) a_nedges++;
    a_done_prev = a_done;
    if (b_dv) begin b_log[b_nbytes[3:0]] = b_byte; b_nbytes++; end
    if (b_ready != 2'b00) b_nready += $countones(b_ready);
    if (b_done && !b_done_prev) b_nedges++;
    b_done_prev = b_done;
  end

  int n_cmp = 0;
  int n_fail = 0;

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] alog(input int i);
    return a_log[i[7:0]];
  endfunction

  function automatic int agrant(input int i);
    return a_grants[i[5:0]];
  endfunction

  task automatic wait_idle(input string tag, input bit use_b, input int budget);
    int k;
    k = 0;
    while (((use_b ? b_busy : a_busy) !== 1'b0) && k < budget) begin step(); k++; end
    check(tag, use_b ? b_busy : a_busy, 1'b0);
  endtask

  // Present mask; a requester drops its bit once accepted unless hold is set.
  task automatic serve_a(input string tag, input logic [3:0] mask, input bit hold,
                         input int nready, input int budget);
    int base, k;
    base = a_nready;
    k = 0;
    a_valid = mask;
    while ((a_nready - base) < nready && k < budget) begin
      step();
      k++;
      if (!hold) a_valid = a_valid & ~a_ready;
    end
    a_valid = 4'b0000;
    check(tag, a_nready - base, nready);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation still running, required finish");
    $fatal(1);
  end

  initial begin
    int b0, r0, e0, g0, rc0, k;
    a_valid = '0; a_data = '0; b_valid = '0; b_data = '0; stub = 1'b0;
    rst = 1'b1;
    step(); step();
    check("rst_ready",   a_ready,   4'b0000);
    check("rst_dv",      a_dv,      1'b0);
    check("rst_byte",    a_byte,    8'h00);
    check("rst_busy",    a_busy,    1'b0);
    check("rst_gid",     a_gid,     2'd0);
    check("rst_timeout", a_timeout, 1'b0);
    check("rst_b_busy",  b_busy,    1'b0);
    rst = 1'b0;
    step();

    // T1: single word from requester 0
    a_data[31:0] = 32'h11223344;
    b0 = a_nbytes; r0 = a_nready; e0 = a_nedges;
    a_valid = 4'b0001;
    step();
    check("t1_ready", a_ready, 4'b0001);
    check("t1_busy",  a_busy,  1'b1);
    check("t1_gid",   a_gid,   2'd0);
    a_valid = 4'b0000;
    step();
    check("t1_dv",    a_dv,    1'b1);
    check("t1_hdr",   a_byte,  8'hA0);
    wait_idle("t1_idle", 1'b0, 400);
    check("t1_nbytes", a_nbytes - b0, 5);
    check("t1_b0", alog(b0),     8'hA0);
    check("t1_b1", alog(b0 + 1), 8'h11);
    check("t1_b2", alog(b0 + 2), 8'h22);
    check("t1_b3", alog(b0 + 3), 8'h33);
    check("t1_b4", alog(b0 + 4), 8'h44);
    check("t1_nready", a_nready - r0, 1);
    check("t1_nedges", a_nedges - e0, 5);

    // T2: all four held valid after a reset returns the pointer to 0
    rst = 1'b1; step(); rst = 1'b0; step();
    a_data = {32'hF0F1F2F3, 32'hE0E1E2E3, 32'hD0D1D2D3, 32'hC0C1C2C3};
    b0 = a_nbytes; r0 = a_nready; g0 = a_ngrant; rc0 = a_rcycles;
    serve_a("t2_serve", 4'b1111, 1'b1, 5, 2000);
    wait_idle("t2_idle", 1'b0, 400);
    check("t2_rcycles", a_rcycles - rc0, 5);
    check("t2_g0", agrant(g0),     0);
    check("t2_g1", agrant(g0 + 1), 1);
    check("t2_g2", agrant(g0 + 2), 2);
    check("t2_g3", agrant(g0 + 3), 3);
    check("t2_g4", agrant(g0 + 4), 0);
    check("t2_h0", alog(b0),      8'hA0);
    check("t2_h1", alog(b0 + 5),  8'hA1);
    check("t2_h2", alog(b0 + 10), 8'hA2);
    check("t2_h3", alog(b0 + 15), 8'hA3);
    check("t2_h4", alog(b0 + 20), 8'hA0);
    check("t2_w2_msb", alog(b0 + 11), 8'hE0);
    check("t2_w3_lsb", alog(b0 + 19), 8'hF3);

    // T3: pointer moved to 2 via requester 1, then 0 and 1 contend
    serve_a("t3_pre", 4'b0010, 1'b0, 1, 50);
    wait_idle("t3_pre_idle", 1'b0, 400);
    g0 = a_ngrant;
    serve_a("t3_serve", 4'b0011, 1'b0, 2, 600);
    wait_idle("t3_idle", 1'b0, 400);
    check("t3_first",  agrant(g0),     0);
    check("t3_second", agrant(g0 + 1), 1);

    // T4: Done suppressed, watchdog aborts, requester 3 follows
    stub = 1'b1;
    a_valid = 4'b1100;
    step();
    check("t4_ready", a_ready, 4'b0100);
    a_valid = 4'b1000;
    step();
    check("t4_dv", a_dv, 1'b1);
    k = 0;
    while (a_timeout !== 1'b1 && k < 100) begin step(); k++; end
    check("t4_timeout_clks", k, 50);
    check("t4_busy", a_busy, 1'b0);
    stub = 1'b0;
    b0 = a_nbytes;
    step();
    check("t4_timeout_pulse", a_timeout, 1'b0);
    check("t4_next_ready", a_ready, 4'b1000);
    check("t4_next_gid", a_gid, 2'd3);
    a_valid = 4'b0000;
    wait_idle("t4_idle", 1'b0, 400);
    check("t4_next_hdr", alog(b0), 8'hA3);

    // T5: reset while the third byte is being handed over
    a_data[63:32] = 32'h55667788;
    b0 = a_nbytes;
    serve_a("t5_serve", 4'b0010, 1'b0, 1, 50);
    k = 0;
    while ((a_nbytes - b0) < 3 && k < 300) begin step(); k++; end
    check("t5_dv_before", a_dv, 1'b1);
    check("t5_gid_before", a_gid, 2'd1);
    rst = 1'b1;
    #1;
    check("t5_dv",    a_dv,    1'b0);
    check("t5_busy",  a_busy,  1'b0);
    check("t5_ready", a_ready, 4'b0000);
    check("t5_gid",   a_gid,   2'd0);
    step();
    rst = 1'b0;
    b0 = a_nbytes;
    serve_a("t5_resend", 4'b0010, 1'b0, 1, 50);
    wait_idle("t5_idle", 1'b0, 400);
    check("t5_nbytes", a_nbytes - b0, 5);
    check("t5_b0", alog(b0),     8'hA1);
    check("t5_b1", alog(b0 + 1), 8'h55);
    check("t5_b4", alog(b0 + 4), 8'h88);

    // T6: single payload byte, no header
    b_data = 16'h005A;
    b0 = b_nbytes; r0 = b_nready; e0 = b_nedges;
    b_valid = 2'b01;
    step();
    check("t6_ready", b_ready, 2'b01);
    b_valid = 2'b00;
    step();
    check("t6_dv",   b_dv,   1'b1);
    check("t6_byte", b_byte, 8'h5A);
    wait_idle("t6_idle", 1'b1, 200);
    repeat (10) step();
    check("t6_nbytes", b_nbytes - b0, 1);
    check("t6_nedges", b_nedges - e0, 1);
    check("t6_nready", b_nready - r0, 1);
    check("t6_log",    b_log[b0[3:0]], 8'h5A);
    check("t6_busy_after", b_busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
